// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the wait-state multicycle MIPS control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_EXC = 3'd5
    } state_t;

    localparam logic [3:0] c_alu_nop  = 4'd0;
    localparam logic [3:0] c_alu_add  = 4'd1;
    localparam logic [3:0] c_alu_sub  = 4'd2;
    localparam logic [3:0] c_alu_and  = 4'd3;
    localparam logic [3:0] c_alu_or   = 4'd4;
    localparam logic [3:0] c_alu_slt  = 4'd5;
    localparam logic [3:0] c_alu_sltu = 4'd6;
    localparam logic [3:0] c_alu_nor  = 4'd7;
    localparam logic [3:0] c_alu_lui  = 4'd8;
    localparam logic [3:0] c_alu_sll  = 4'd9;
    localparam logic [3:0] c_alu_srl  = 4'd10;
    localparam logic [3:0] c_alu_sllv = 4'd11;
    localparam logic [3:0] c_alu_srlv = 4'd12;

    localparam logic [2:0] c_pcs_alu    = 3'd0;
    localparam logic [2:0] c_pcs_aluout = 3'd1;
    localparam logic [2:0] c_pcs_jump   = 3'd2;
    localparam logic [2:0] c_pcs_rs     = 3'd3;
    localparam logic [2:0] c_pcs_exc    = 3'd4;

    localparam logic [1:0] c_gpr_rd = 2'd0;
    localparam logic [1:0] c_gpr_rt = 2'd1;
    localparam logic [1:0] c_gpr_ra = 2'd2;

    localparam logic [1:0] c_wd_alu = 2'd0;
    localparam logic [1:0] c_wd_mem = 2'd1;
    localparam logic [1:0] c_wd_pc  = 2'd2;

    localparam logic [1:0] c_srca_pc    = 2'd0;
    localparam logic [1:0] c_srca_rs    = 2'd1;
    localparam logic [1:0] c_srca_shamt = 2'd2;
    localparam logic [1:0] c_srca_rsv   = 2'd3;

    localparam logic [1:0] c_srcb_rt    = 2'd0;
    localparam logic [1:0] c_srcb_four  = 2'd1;
    localparam logic [1:0] c_srcb_imm   = 2'd2;
    localparam logic [1:0] c_srcb_brofs = 2'd3;

    localparam logic [1:0] c_exc_none    = 2'd0;
    localparam logic [1:0] c_exc_illegal = 2'd1;
    localparam logic [1:0] c_exc_bus     = 2'd2;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_jalr = 6'h09;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    typedef struct packed {
        logic is_add, is_addu, is_sub, is_subu, is_and, is_or, is_nor;
        logic is_slt, is_sltu, is_sll, is_srl, is_sllv, is_srlv;
        logic is_jr, is_jalr;
        logic is_addi, is_slti, is_andi, is_ori, is_lui;
        logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
        logic i_valid;
    } dec_t;

    function automatic logic [3:0] alu_op_of(input dec_t d);
        logic [3:0] op;
        op = c_alu_nop;
        if (d.is_add | d.is_addu | d.is_addi | d.is_lw | d.is_sw) op = c_alu_add;
        else if (d.is_sub | d.is_subu | d.is_beq | d.is_bne)     op = c_alu_sub;
        else if (d.is_and | d.is_andi)                            op = c_alu_and;
        else if (d.is_or | d.is_ori)                              op = c_alu_or;
        else if (d.is_slt | d.is_slti)                            op = c_alu_slt;
        else if (d.is_sltu)                                       op = c_alu_sltu;
        else if (d.is_nor)                                        op = c_alu_nor;
        else if (d.is_lui)                                        op = c_alu_lui;
        else if (d.is_sll)                                        op = c_alu_sll;
        else if (d.is_srl)                                        op = c_alu_srl;
        else if (d.is_sllv)                                       op = c_alu_sllv;
        else if (d.is_srlv)                                       op = c_alu_srlv;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Op/Funct to one-hot instruction flags; unknown encodings clear i_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.i_valid = 1'b1;
        case (i_op)
            c_op_rtype: begin
                case (i_funct)
                    c_fn_add:  o_dec.is_add  = 1'b1;
                    c_fn_addu: o_dec.is_addu = 1'b1;
                    c_fn_sub:  o_dec.is_sub  = 1'b1;
                    c_fn_subu: o_dec.is_subu = 1'b1;
                    c_fn_and:  o_dec.is_and  = 1'b1;
                    c_fn_or:   o_dec.is_or   = 1'b1;
                    c_fn_nor:  o_dec.is_nor  = 1'b1;
                    c_fn_slt:  o_dec.is_slt  = 1'b1;
                    c_fn_sltu: o_dec.is_sltu = 1'b1;
                    c_fn_sll:  o_dec.is_sll  = 1'b1;
                    c_fn_srl:  o_dec.is_srl  = 1'b1;
                    c_fn_sllv: o_dec.is_sllv = 1'b1;
                    c_fn_srlv: o_dec.is_srlv = 1'b1;
                    c_fn_jr:   o_dec.is_jr   = 1'b1;
                    c_fn_jalr: o_dec.is_jalr = 1'b1;
                    default:   o_dec.i_valid = 1'b0;
                endcase
            end
            c_op_addi: o_dec.is_addi = 1'b1;
            c_op_slti: o_dec.is_slti = 1'b1;
            c_op_andi: o_dec.is_andi = 1'b1;
            c_op_ori:  o_dec.is_ori  = 1'b1;
            c_op_lui:  o_dec.is_lui  = 1'b1;
            c_op_lw:   o_dec.is_lw   = 1'b1;
            c_op_sw:   o_dec.is_sw   = 1'b1;
            c_op_beq:  o_dec.is_beq  = 1'b1;
            c_op_bne:  o_dec.is_bne  = 1'b1;
            c_op_j:    o_dec.is_j    = 1'b1;
            c_op_jal:  o_dec.is_jal  = 1'b1;
            default:   o_dec.i_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_ws
// Description : Multicycle MIPS control FSM with memory wait states, bus timeout,
//               illegal-instruction trap and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_ws
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int EXC_EN      = 1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Zero,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               EPCWrite,
    output logic               EXTOp,
    output logic               IorD,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [2:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         exc_cause,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instret
);

    localparam logic [TO_W-1:0] c_wait_lim = TO_W'(MEM_TIMEOUT);

    dec_t             w_dec;
    state_t           r_state, w_state_nx;
    logic [TO_W-1:0]  r_wcnt;
    logic [1:0]       r_exc_cause, w_cause_nx;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire, w_timeout, w_itype;
    logic             w_mem_req, w_reg_write, w_mem_write, w_ir_write, w_pc_write, w_epc_write;

    mc_decode u_decode (
        .i_op    (Op),
        .i_funct (Funct),
        .o_dec   (w_dec)
    );

    assign w_itype   = w_dec.is_addi | w_dec.is_ori | w_dec.is_andi | w_dec.is_slti | w_dec.is_lui;
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wcnt == c_wait_lim) && !mem_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_cause_nx  = r_exc_cause;
        w_retire    = 1'b0;
        w_mem_req   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_epc_write = 1'b0;
        EXTOp       = 1'b1;
        IorD        = 1'b0;
        ALUSrcA     = c_srca_rs;
        ALUSrcB     = c_srcb_rt;
        GPRSel      = c_gpr_rd;
        WDSel       = c_wd_alu;
        PCSource    = c_pcs_alu;
        ALUOp       = ALUOP_W'(c_alu_add);
        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                ALUSrcA   = c_srca_pc;
                ALUSrcB   = c_srcb_four;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_state_nx = S_ID;
                end else if (w_timeout) begin
                    w_state_nx = S_EXC;
                    w_cause_nx = c_exc_bus;
                end
            end
            S_ID: begin
                if (!w_dec.i_valid) begin
                    if (EXC_EN != 0) begin
                        w_state_nx = S_EXC;
                        w_cause_nx = c_exc_illegal;
                    end else begin
                        w_state_nx = S_IF;
                    end
                end else if (w_dec.is_j | w_dec.is_jal | w_dec.is_jr | w_dec.is_jalr) begin
                    PCSource   = (w_dec.is_j | w_dec.is_jal) ? c_pcs_jump : c_pcs_rs;
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                    w_state_nx = S_IF;
                    if (w_dec.is_jal | w_dec.is_jalr) begin
                        w_reg_write = 1'b1;
                        WDSel       = c_wd_pc;
                        GPRSel      = w_dec.is_jal ? c_gpr_ra : c_gpr_rd;
                    end
                end else begin
                    // Precompute the branch target while the register file is read.
                    ALUSrcA    = c_srca_pc;
                    ALUSrcB    = c_srcb_brofs;
                    w_state_nx = S_EXE;
                end
            end
            S_EXE: begin
                ALUOp = ALUOP_W'(alu_op_of(w_dec));
                if (w_dec.is_beq | w_dec.is_bne) begin
                    PCSource   = c_pcs_aluout;
                    w_pc_write = w_dec.is_beq ? Zero : !Zero;
                    w_retire   = 1'b1;
                    w_state_nx = S_IF;
                end else if (w_dec.is_lw | w_dec.is_sw) begin
                    ALUSrcB    = c_srcb_imm;
                    w_state_nx = S_MEM;
                end else begin
                    if (w_itype)                       ALUSrcB = c_srcb_imm;
                    if (w_dec.is_ori | w_dec.is_andi)  EXTOp   = 1'b0;
                    if (w_dec.is_sll | w_dec.is_srl)   ALUSrcA = c_srca_shamt;
                    if (w_dec.is_sllv | w_dec.is_srlv) ALUSrcA = c_srca_rsv;
                    w_state_nx = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                IorD        = 1'b1;
                w_mem_write = w_dec.is_sw;
                if (mem_ready) begin
                    w_state_nx = w_dec.is_lw ? S_WB : S_IF;
                    w_retire   = w_dec.is_sw;
                end else if (w_timeout) begin
                    w_state_nx = S_EXC;
                    w_cause_nx = c_exc_bus;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_state_nx  = S_IF;
                if (w_dec.is_lw)           WDSel  = c_wd_mem;
                if (w_dec.is_lw | w_itype) GPRSel = c_gpr_rt;
            end
            S_EXC: begin
                w_epc_write = 1'b1;
                w_pc_write  = 1'b1;
                PCSource    = c_pcs_exc;
                w_state_nx  = S_IF;
            end
            default: w_state_nx = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IF;
            r_wcnt      <= '0;
            r_exc_cause <= c_exc_none;
            r_instret   <= '0;
        end else begin
            r_state     <= w_state_nx;
            // Any state change restarts the wait count for the next access.
            r_wcnt      <= (w_state_nx != r_state) ? '0 : r_wcnt + TO_W'(1);
            r_exc_cause <= w_cause_nx;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Strobes are gated by reset so an access in flight is dropped immediately.
    assign mem_req   = rst & w_mem_req;
    assign RegWrite  = rst & w_reg_write;
    assign MemWrite  = rst & w_mem_write;
    assign IRWrite   = rst & w_ir_write;
    assign PCWrite   = rst & w_pc_write;
    assign EPCWrite  = rst & w_epc_write;
    assign exc_cause = r_exc_cause;
    assign state_o   = r_state;
    assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_ws
// Description : Instruction-level reference bench for mc_ctrl_ws.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_ws;

    localparam int TMO = 15;
    localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_EXC = 5;
    localparam int K_R = 0, K_SH = 1, K_SHV = 2, K_I = 3, K_IZ = 4, K_LW = 5, K_SW = 6;
    localparam int K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_JALR = 12, K_ILL = 13;
    localparam int I_ADDI = 15, I_LW = 20, I_SW = 21, I_BEQ = 22, I_ILL = 26;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] kind;
        logic [3:0] aop;
    } ins_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        mreq, mw, irw, pcw, rw, epcw, iord, ext;
        logic [1:0]  sa, sb, gs, wd;
        logic [2:0]  pcs;
        logic [3:0]  aop;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } ctl_t;

    ins_t tbl [0:27] = '{
        '{6'h00, 6'h20, 4'd0, 4'd1},  '{6'h00, 6'h21, 4'd0, 4'd1},
        '{6'h00, 6'h22, 4'd0, 4'd2},  '{6'h00, 6'h23, 4'd0, 4'd2},
        '{6'h00, 6'h24, 4'd0, 4'd3},  '{6'h00, 6'h25, 4'd0, 4'd4},
        '{6'h00, 6'h27, 4'd0, 4'd7},  '{6'h00, 6'h2A, 4'd0, 4'd5},
        '{6'h00, 6'h2B, 4'd0, 4'd6},  '{6'h00, 6'h00, 4'd1, 4'd9},
        '{6'h00, 6'h02, 4'd1, 4'd10}, '{6'h00, 6'h04, 4'd2, 4'd11},
        '{6'h00, 6'h06, 4'd2, 4'd12}, '{6'h00, 6'h08, 4'd11, 4'd1},
        '{6'h00, 6'h09, 4'd12, 4'd1}, '{6'h08, 6'h15, 4'd3, 4'd1},
        '{6'h0A, 6'h00, 4'd3, 4'd5},  '{6'h0C, 6'h3F, 4'd4, 4'd3},
        '{6'h0D, 6'h00, 4'd4, 4'd4},  '{6'h0F, 6'h00, 4'd3, 4'd8},
        '{6'h23, 6'h00, 4'd5, 4'd1},  '{6'h2B, 6'h00, 4'd6, 4'd1},
        '{6'h04, 6'h00, 4'd7, 4'd2},  '{6'h05, 6'h00, 4'd8, 4'd2},
        '{6'h02, 6'h00, 4'd9, 4'd1},  '{6'h03, 6'h00, 4'd10, 4'd1},
        '{6'h3F, 6'h00, 4'd13, 4'd1}, '{6'h00, 6'h3F, 4'd13, 4'd1}
    };

    logic        clk = 1'b0, rst = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
    logic [5:0]  Op = 6'h00, Funct = 6'h20;

    logic        mem_req, RegWrite, MemWrite, IRWrite, PCWrite, EPCWrite, EXTOp, IorD;
    logic [1:0]  ALUSrcA, ALUSrcB, GPRSel, WDSel, exc_cause;
    logic [2:0]  PCSource, state_o;
    logic [3:0]  ALUOp;
    logic [31:0] instret;

    logic        z_mem_req, z_RegWrite, z_MemWrite, z_IRWrite, z_PCWrite, z_EPCWrite, z_EXTOp, z_IorD;
    logic [1:0]  z_ALUSrcA, z_ALUSrcB, z_GPRSel, z_WDSel, z_exc_cause;
    logic [2:0]  z_PCSource, z_state_o;
    logic [3:0]  z_ALUOp;
    logic [31:0] z_instret;

    int          checks = 0, failures = 0;
    logic [31:0] exp_cnt = 0;
    logic [1:0]  exp_cause = 0;
    ctl_t        obs;

    always #5 clk = ~clk;

    mc_ctrl_ws #(.ALUOP_W(4), .MEM_TIMEOUT(TMO), .TO_W(4), .EXC_EN(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .EPCWrite(EPCWrite), .EXTOp(EXTOp), .IorD(IorD),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel),
        .PCSource(PCSource), .ALUOp(ALUOp), .exc_cause(exc_cause), .state_o(state_o),
        .instret(instret)
    );

    mc_ctrl_ws #(.ALUOP_W(4), .MEM_TIMEOUT(TMO), .TO_W(4), .EXC_EN(0), .CNT_W(32)) dut_noexc (
        .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(z_mem_req), .RegWrite(z_RegWrite), .MemWrite(z_MemWrite), .IRWrite(z_IRWrite),
        .PCWrite(z_PCWrite), .EPCWrite(z_EPCWrite), .EXTOp(z_EXTOp), .IorD(z_IorD),
        .ALUSrcA(z_ALUSrcA), .ALUSrcB(z_ALUSrcB), .GPRSel(z_GPRSel), .WDSel(z_WDSel),
        .PCSource(z_PCSource), .ALUOp(z_ALUOp), .exc_cause(z_exc_cause), .state_o(z_state_o),
        .instret(z_instret)
    );

    assign obs = {state_o, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, EPCWrite, IorD, EXTOp,
                  ALUSrcA, ALUSrcB, GPRSel, WDSel, PCSource, ALUOp, exc_cause, instret};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Expected control word for one phase of an instruction, straight from the control table.
    function automatic ctl_t mk(input int ph, input int kd, input logic [3:0] aop,
                                input logic z, input logic rdy);
        ctl_t c;
        c = '0;
        c.st = 3'(ph); c.ext = 1'b1; c.sa = 2'd1; c.aop = 4'd1;
        c.cause = exp_cause; c.cnt = exp_cnt;
        case (ph)
            P_IF:  begin c.mreq = 1; c.sa = 0; c.sb = 1; c.irw = rdy; c.pcw = rdy; end
            P_ID:  begin
                case (kd)
                    K_J:    begin c.pcs = 2; c.pcw = 1; end
                    K_JAL:  begin c.pcs = 2; c.pcw = 1; c.rw = 1; c.wd = 2; c.gs = 2; end
                    K_JR:   begin c.pcs = 3; c.pcw = 1; end
                    K_JALR: begin c.pcs = 3; c.pcw = 1; c.rw = 1; c.wd = 2; end
                    K_ILL:  ;
                    default: begin c.sa = 0; c.sb = 3; end
                endcase
            end
            P_EXE: begin
                c.aop = aop;
                case (kd)
                    K_BEQ:      begin c.pcs = 1; c.pcw = z; end
                    K_BNE:      begin c.pcs = 1; c.pcw = !z; end
                    K_LW, K_SW: c.sb = 2;
                    K_I:        c.sb = 2;
                    K_IZ:       begin c.sb = 2; c.ext = 0; end
                    K_SH:       c.sa = 2;
                    K_SHV:      c.sa = 3;
                    default:    ;
                endcase
            end
            P_MEM: begin c.mreq = 1; c.iord = 1; c.mw = (kd == K_SW); end
            P_WB:  begin
                c.rw = 1;
                if (kd == K_LW) begin c.wd = 1; c.gs = 1; end
                if (kd == K_I || kd == K_IZ) c.gs = 1;
            end
            P_EXC: begin c.epcw = 1; c.pcw = 1; c.pcs = 4; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic cyc(input logic rdy, input ctl_t e, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, 64'(obs), 64'(e));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_ready = 1'b0;
        exp_cnt = 0; exp_cause = 0;
        @(negedge clk);
        chk("reset_state", {state_o, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, EPCWrite,
                            exc_cause, instret}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic take_exc(input logic [1:0] cause);
        exp_cause = cause;
        cyc(1'($urandom_range(0, 1)), mk(P_EXC, K_R, 4'd1, 1'b0, 1'b0), "exc");
    endtask

    // One instruction: ifw/memw are wait cycles before mem_ready (beyond TMO means timeout);
    // rst_k >= 0 pulses reset in that MEM cycle instead of completing the access.
    task automatic run_instr(input int idx, input logic z, input int ifw, input int memw, input int rst_k);
        ins_t it;
        int   kd;
        logic r;
        it = tbl[idx];
        kd = int'(it.kind);
        Op = it.op; Funct = it.fn; Zero = z;
        for (int k = 0; k <= TMO; k++) begin
            r = (k == ifw);
            cyc(r, mk(P_IF, kd, it.aop, z, r), "if");
            if (r) break;
            if (k == TMO) begin take_exc(2'd2); return; end
        end
        cyc(1'($urandom_range(0, 1)), mk(P_ID, kd, it.aop, z, 1'b0), "id");
        if (kd == K_ILL) begin take_exc(2'd1); return; end
        if (kd >= K_J) begin exp_cnt++; return; end
        cyc(1'($urandom_range(0, 1)), mk(P_EXE, kd, it.aop, z, 1'b0), "exe");
        if (kd == K_BEQ || kd == K_BNE) begin exp_cnt++; return; end
        if (kd == K_LW || kd == K_SW) begin
            for (int k = 0; k <= TMO; k++) begin
                if (k == rst_k) begin
                    mem_ready = 1'b0;
                    chk("pre_rst_strobes", {MemWrite, mem_req}, 64'd3);
                    rst = 1'b0;
                    #1;
                    chk("async_rst_drop", {MemWrite, mem_req, state_o}, 64'd0);
                    exp_cnt = 0; exp_cause = 0;
                    @(negedge clk); @(posedge clk); #1;
                    rst = 1'b1;
                    return;
                end
                r = (k == memw);
                cyc(r, mk(P_MEM, kd, it.aop, z, r), "mem");
                if (r) break;
                if (k == TMO) begin take_exc(2'd2); return; end
            end
            if (kd == K_SW) begin exp_cnt++; return; end
        end
        cyc(1'($urandom_range(0, 1)), mk(P_WB, kd, it.aop, z, 1'b0), "wb");
        exp_cnt++;
    endtask

    initial begin
        #2;
        do_reset();
        run_instr(I_ADDI, 1'b0, 0, 0, -1);
        run_instr(I_LW, 1'b0, 2, 3, -1);
        run_instr(I_BEQ, 1'b0, 0, 0, -1);
        run_instr(I_BEQ, 1'b1, 1, 0, -1);
        run_instr(I_SW, 1'b0, 0, 99, -1);
        run_instr(I_ADDI, 1'b0, TMO + 1, 0, -1);
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 27)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 11) == 0) ? TMO + 1 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? TMO + 5 : int'($urandom_range(0, 4)), -1);
        end

        // Same illegal opcode on both trap configurations.
        do_reset();
        Op = tbl[I_ILL].op; Funct = tbl[I_ILL].fn;
        cyc(1'b1, mk(P_IF, K_ILL, 4'd1, 1'b0, 1'b1), "ill_if");
        mem_ready = 1'b0;
        @(negedge clk);
        chk("ill_id", 64'(obs), 64'(mk(P_ID, K_ILL, 4'd1, 1'b0, 1'b0)));
        chk("noexc_id", {z_state_o, z_EPCWrite}, {3'd1, 1'b0});
        @(posedge clk); #1;
        exp_cause = 2'd1;
        @(negedge clk);
        chk("ill_exc", 64'(obs), 64'(mk(P_EXC, K_ILL, 4'd1, 1'b0, 1'b0)));
        chk("noexc_back_to_if", {z_state_o, z_EPCWrite, z_exc_cause, z_mem_req}, {3'd0, 1'b0, 2'd0, 1'b1});
        @(posedge clk); #1;

        run_instr(I_SW, 1'b0, 0, 99, 2);
        run_instr(I_ADDI, 1'b0, 0, 0, -1);
        run_instr(I_LW, 1'b1, 1, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
